// File: rtl/jtpopeye_rom_arb_if.sv
// SDRAM read-port bundle shared between the ROM arbiter and the
// jtframe SDRAM controller.
interface jtpopeye_rom_arb_if;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic [31:0] data_read;
  logic        data_rdy;

  modport master (
    output sdram_addr, sdram_req,
    input  sdram_ack, data_read, data_rdy
  );

  modport slave (
    input  sdram_addr, sdram_req,
    output sdram_ack, data_read, data_rdy
  );
endinterface

// File: rtl/jtpopeye_rom_arb.sv
// Three-slot ROM arbiter for jtpopeye_game: one-word cache per slot,
// misses fetched one at a time from the shared SDRAM read port.
module jtpopeye_rom_arb #(
  parameter int          AW0     = 15,
  parameter int          AW1     = 13,
  parameter int          AW2     = 13,
  parameter logic [21:0] OFFSET1 = 22'h4000,
  parameter logic [21:0] OFFSET2 = 22'h8000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           downloading,
  input  logic           slot0_cs,
  input  logic [AW0-1:0] slot0_addr,
  output logic [7:0]     slot0_dout,
  output logic           slot0_ok,
  input  logic           slot1_cs,
  input  logic [AW1-1:0] slot1_addr,
  output logic [31:0]    slot1_dout,
  output logic           slot1_ok,
  input  logic           slot2_cs,
  input  logic [AW2-1:0] slot2_addr,
  output logic [31:0]    slot2_dout,
  output logic           slot2_ok,
  output logic           refresh_en,
  jtpopeye_rom_arb_if.master sdram
);
  localparam int TW0 = AW0 - 2;
  localparam int TWA = TW0 > AW1 ? TW0 : AW1;
  localparam int TW  = TWA > AW2 ? TWA : AW2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_n;
  logic            req_q, req_n;
  logic [21:0]     addr_q, addr_n;
  logic [1:0]      sel_q, sel_n;
  logic [TW-1:0]   ltag_q, ltag_n;
  logic            wr;
  logic [2:0]      valid;
  logic [TW0-1:0]  tag0;
  logic [AW1-1:0]  tag1;
  logic [AW2-1:0]  tag2;
  logic [31:0]     data0, data1, data2;
  logic [TW0-1:0]  cur0;
  logic            hit0, hit1, hit2;
  logic            miss0, miss1, miss2;

  assign cur0 = slot0_addr[AW0-1:2];

  assign hit0 = valid[0] & (tag0 == cur0);
  assign hit1 = valid[1] & (tag1 == slot1_addr);
  assign hit2 = valid[2] & (tag2 == slot2_addr);

  assign slot0_ok = slot0_cs & hit0;
  assign slot1_ok = slot1_cs & hit1;
  assign slot2_ok = slot2_cs & hit2;

  assign miss0 = slot0_cs & ~hit0;
  assign miss1 = slot1_cs & ~hit1;
  assign miss2 = slot2_cs & ~hit2;

  assign slot0_dout = data0[{slot0_addr[1:0], 3'b000} +: 8];
  assign slot1_dout = data1;
  assign slot2_dout = data2;

  assign refresh_en       = state == IDLE;
  assign sdram.sdram_req  = req_q;
  assign sdram.sdram_addr = addr_q;

  always_comb begin
    state_n = state;
    req_n   = req_q;
    addr_n  = addr_q;
    sel_n   = sel_q;
    ltag_n  = ltag_q;
    wr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (miss0) begin
          sel_n  = 2'd0;
          ltag_n = TW'(cur0);
          addr_n = 22'({cur0, 1'b0});
        end else if (miss1) begin
          sel_n  = 2'd1;
          ltag_n = TW'(slot1_addr);
          addr_n = OFFSET1 + 22'({slot1_addr, 1'b0});
        end else if (miss2) begin
          sel_n  = 2'd2;
          ltag_n = TW'(slot2_addr);
          addr_n = OFFSET2 + 22'({slot2_addr, 1'b0});
        end
        if (miss0 | miss1 | miss2) begin
          state_n = REQ;
          req_n   = 1'b1;
        end
      end
      REQ: begin
        if (sdram.sdram_ack) begin
          req_n   = 1'b0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (sdram.data_rdy) begin
          wr      = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // download abandons any fetch; a late data_rdy lands in IDLE
    if (downloading) begin
      state_n = IDLE;
      req_n   = 1'b0;
      wr      = 1'b0;
      addr_n  = addr_q;
      sel_n   = sel_q;
      ltag_n  = ltag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      addr_q <= '0;
      sel_q  <= '0;
      ltag_q <= '0;
      valid  <= '0;
      tag0   <= '0;
      tag1   <= '0;
      tag2   <= '0;
      data0  <= '0;
      data1  <= '0;
      data2  <= '0;
    end else begin
      state  <= state_n;
      req_q  <= req_n;
      addr_q <= addr_n;
      sel_q  <= sel_n;
      ltag_q <= ltag_n;
      if (downloading) begin
        valid <= '0;
      end else if (wr) begin
        unique case (sel_q)
          2'd0: begin
            valid[0] <= 1'b1;
            tag0     <= ltag_q[TW0-1:0];
            data0    <= sdram.data_read;
          end
          2'd1: begin
            valid[1] <= 1'b1;
            tag1     <= ltag_q[AW1-1:0];
            data1    <= sdram.data_read;
          end
          2'd2: begin
            valid[2] <= 1'b1;
            tag2     <= ltag_q[AW2-1:0];
            data2    <= sdram.data_read;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtpopeye_rom_arb.sv
// Bench for jtpopeye_rom_arb: directed sequences, a hit/miss vector
// table and random traffic against a slot-cache reference model.
module tb_jtpopeye_rom_arb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic        cs0 = 1'b0, cs1 = 1'b0, cs2 = 1'b0;
  logic [14:0] a0 = '0;
  logic [12:0] a1 = '0, a2 = '0;
  logic [7:0]  d0;
  logic [31:0] d1, d2;
  logic        ok0, ok1, ok2, refresh_en;

  logic        w_cs2 = 1'b0, z_cs = 1'b0;
  logic [14:0] z_a0 = '0;
  logic [12:0] z_a1 = '0, w_a2 = '0;
  logic [7:0]  w_d0;
  logic [31:0] w_d1, w_d2;
  logic        w_ok0, w_ok1, w_ok2, w_refresh;

  int n_tests = 0;
  int n_fail  = 0;

  jtpopeye_rom_arb_if sd ();
  jtpopeye_rom_arb_if sdw ();

  jtpopeye_rom_arb dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .slot0_cs(cs0), .slot0_addr(a0), .slot0_dout(d0), .slot0_ok(ok0),
    .slot1_cs(cs1), .slot1_addr(a1), .slot1_dout(d1), .slot1_ok(ok1),
    .slot2_cs(cs2), .slot2_addr(a2), .slot2_dout(d2), .slot2_ok(ok2),
    .refresh_en(refresh_en), .sdram(sd)
  );

  jtpopeye_rom_arb #(.OFFSET2(22'h3FFFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .slot0_cs(z_cs), .slot0_addr(z_a0), .slot0_dout(w_d0), .slot0_ok(w_ok0),
    .slot1_cs(z_cs), .slot1_addr(z_a1), .slot1_dout(w_d1), .slot1_ok(w_ok1),
    .slot2_cs(w_cs2), .slot2_addr(w_a2), .slot2_dout(w_d2), .slot2_ok(w_ok2),
    .refresh_en(w_refresh), .sdram(sdw)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    logic        cs;
    logic [14:0] addr;
    logic        exp_ok;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_ok(input int s);
    return s == 0 ? ok0 : (s == 1 ? ok1 : ok2);
  endfunction

  function automatic logic [31:0] get_dout(input int s);
    return s == 0 ? {24'h0, d0} : (s == 1 ? d1 : d2);
  endfunction

  task automatic wait_req(input string nm, input int max_w,
                          input logic [21:0] exp_addr);
    int w = 0;
    while (!sd.sdram_req && w < max_w) begin
      tick();
      w++;
    end
    chk({nm, "_req"}, 64'(sd.sdram_req), 64'(1));
    chk({nm, "_addr"}, 64'(sd.sdram_addr), 64'(exp_addr));
    chk({nm, "_refresh_req"}, 64'(refresh_en), 64'(0));
  endtask

  task automatic do_ack(input string nm, input int dly);
    repeat (dly) begin
      tick();
      chk({nm, "_req_hold"}, 64'(sd.sdram_req), 64'(1));
    end
    sd.sdram_ack = 1'b1;
    tick();
    sd.sdram_ack = 1'b0;
    chk({nm, "_req_drop"}, 64'(sd.sdram_req), 64'(0));
    chk({nm, "_refresh_wait"}, 64'(refresh_en), 64'(0));
  endtask

  task automatic do_data(input string nm, input int dly,
                         input logic [31:0] d);
    repeat (dly) begin
      tick();
      chk({nm, "_refresh_wait"}, 64'(refresh_en), 64'(0));
    end
    sd.data_read = d;
    sd.data_rdy  = 1'b1;
    tick();
    sd.data_rdy  = 1'b0;
    sd.data_read = '0;
    chk({nm, "_refresh_idle"}, 64'(refresh_en), 64'(1));
  endtask

  // reference model: one cached word per slot
  logic        mv[3];
  int          mt[3];
  logic [31:0] md[3];

  function automatic int mtag(input int s, input int addr);
    return s == 0 ? addr / 4 : addr;
  endfunction

  function automatic logic [21:0] maddr(input int s, input int addr);
    int base;
    base = s == 0 ? 0 : (s == 1 ? 'h4000 : 'h8000);
    if (s == 0) return 22'((addr / 4) * 2);
    return 22'((base + addr * 2) % (1 << 22));
  endfunction

  function automatic logic [31:0] mdout(input int s, input int addr);
    logic [31:0] w;
    w = md[s];
    if (s == 0) return {24'h0, 8'(w >> (8 * (addr % 4)))};
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sd.sdram_ack = 1'b0;
    sd.data_rdy  = 1'b0;
    sd.data_read = '0;
    sdw.sdram_ack = 1'b0;
    sdw.data_rdy  = 1'b0;
    sdw.data_read = '0;

    vecs[0] = '{0, 1'b1, 15'h4, 1'b1, 32'hAA};
    vecs[1] = '{0, 1'b1, 15'h5, 1'b1, 32'hBB};
    vecs[2] = '{0, 1'b1, 15'h6, 1'b1, 32'hCC};
    vecs[3] = '{0, 1'b1, 15'h7, 1'b1, 32'hDD};
    vecs[4] = '{0, 1'b1, 15'h8, 1'b0, 32'h0};
    vecs[5] = '{0, 1'b0, 15'h5, 1'b0, 32'h0};
    vecs[6] = '{1, 1'b1, 15'h10, 1'b1, 32'h11112222};
    vecs[7] = '{1, 1'b1, 15'h11, 1'b0, 32'h0};
    vecs[8] = '{2, 1'b1, 15'h20, 1'b1, 32'h33334444};
    vecs[9] = '{2, 1'b1, 15'h21, 1'b0, 32'h0};

    // reset with every requester active
    cs0 = 1'b1; cs1 = 1'b1; cs2 = 1'b1;
    a0 = 15'h123; a1 = 13'h5; a2 = 13'h6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req", 64'(sd.sdram_req), 64'(0));
      chk("rst_addr", 64'(sd.sdram_addr), 64'(0));
      chk("rst_ok", 64'({ok0, ok1, ok2}), 64'(0));
      chk("rst_dout", 64'({d0, d1, d2}), 64'(0));
      chk("rst_refresh", 64'(refresh_en), 64'(1));
    end
    cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
    rst_n = 1'b1;
    tick();

    // slot 0 miss then hit
    cs0 = 1'b1; a0 = 15'h0005;
    #1 chk("s0_miss_ok", 64'(ok0), 64'(0));
    wait_req("s0", 1, 22'h2);
    do_ack("s0", 2);
    do_data("s0", 3, 32'hDDCCBBAA);
    chk("s0_ok", 64'(ok0), 64'(1));
    chk("s0_dout", 64'(d0), 64'hBB);
    a0 = 15'h0007;
    #1;
    chk("s0_hit_ok", 64'(ok0), 64'(1));
    chk("s0_hit_dout", 64'(d0), 64'hDD);
    tick();
    chk("s0_hit_noreq", 64'(sd.sdram_req), 64'(0));
    cs0 = 1'b0;

    // contention between slot 1 and slot 2
    cs1 = 1'b1; a1 = 13'h10;
    cs2 = 1'b1; a2 = 13'h20;
    wait_req("c1", 1, 22'h4020);
    do_ack("c1", 1);
    do_data("c1", 1, 32'h11112222);
    chk("c1_ok", 64'(ok1), 64'(1));
    chk("c1_dout", 64'(d1), 64'h11112222);
    chk("c1_ok2_pending", 64'(ok2), 64'(0));
    wait_req("c2", 1, 22'h8040);
    do_ack("c2", 0);
    do_data("c2", 2, 32'h33334444);
    chk("c2_ok", 64'(ok2), 64'(1));
    chk("c2_dout", 64'(d2), 64'h33334444);
    cs1 = 1'b0; cs2 = 1'b0;

    // hit/miss vector table, one vector per cycle
    for (int i = 0; i < 10; i++) begin
      tick();
      cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
      case (vecs[i].slot)
        0: begin cs0 = vecs[i].cs; a0 = vecs[i].addr; end
        1: begin cs1 = vecs[i].cs; a1 = vecs[i].addr[12:0]; end
        default: begin cs2 = vecs[i].cs; a2 = vecs[i].addr[12:0]; end
      endcase
      #1;
      chk($sformatf("vec%0d_ok", i), 64'(get_ok(vecs[i].slot)),
          64'(vecs[i].exp_ok));
      if (vecs[i].exp_ok)
        chk($sformatf("vec%0d_dout", i), 64'(get_dout(vecs[i].slot)),
            64'(vecs[i].exp_dout));
      cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
    end
    tick();
    chk("vec_noreq", 64'(sd.sdram_req), 64'(0));

    // download abort during WAIT
    cs0 = 1'b1; a0 = 15'h100;
    wait_req("dl", 1, 22'h80);
    do_ack("dl", 0);
    downloading = 1'b1;
    tick();
    chk("dl_req", 64'(sd.sdram_req), 64'(0));
    chk("dl_refresh", 64'(refresh_en), 64'(1));
    sd.data_read = 32'hDEADBEEF;
    sd.data_rdy  = 1'b1;
    tick();
    sd.data_rdy  = 1'b0;
    chk("dl_late_ok", 64'(ok0), 64'(0));
    cs1 = 1'b1; a1 = 13'h10;
    #1 chk("dl_inval_ok1", 64'(ok1), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dl_noreq", 64'(sd.sdram_req), 64'(0));
    end
    cs1 = 1'b0;
    downloading = 1'b0;
    wait_req("dl2", 1, 22'h80);
    do_ack("dl2", 0);
    do_data("dl2", 0, 32'hA5A55A5A);
    chk("dl2_ok", 64'(ok0), 64'(1));
    chk("dl2_dout", 64'(d0), 64'h5A);
    cs0 = 1'b0;

    // address change mid-fetch
    cs1 = 1'b1; a1 = 13'h10;
    wait_req("mf", 1, 22'h4020);
    do_ack("mf", 0);
    a1 = 13'h11;
    #1 chk("mf_wait_ok", 64'(ok1), 64'(0));
    do_data("mf", 1, 32'h0BADF00D);
    chk("mf_ok_after", 64'(ok1), 64'(0));
    a1 = 13'h10;
    #1;
    chk("mf_tag_ok", 64'(ok1), 64'(1));
    chk("mf_tag_dout", 64'(d1), 64'h0BADF00D);
    a1 = 13'h11;
    #1;
    wait_req("mf2", 1, 22'h4022);
    do_ack("mf2", 0);
    do_data("mf2", 0, 32'h600DCAFE);
    chk("mf2_ok", 64'(ok1), 64'(1));
    chk("mf2_dout", 64'(d1), 64'h600DCAFE);
    cs1 = 1'b0;

    // OFFSET2 wrap on the second instance
    w_cs2 = 1'b1; w_a2 = 13'h2;
    tick();
    chk("wrap_req", 64'(sdw.sdram_req), 64'(1));
    chk("wrap_addr", 64'(sdw.sdram_addr), 64'h000002);
    sdw.sdram_ack = 1'b1;
    tick();
    sdw.sdram_ack = 1'b0;
    sdw.data_read = 32'hCAFEF00D;
    sdw.data_rdy  = 1'b1;
    tick();
    sdw.data_rdy  = 1'b0;
    chk("wrap_ok", 64'(w_ok2), 64'(1));
    chk("wrap_dout", 64'(w_d2), 64'hCAFEF00D);
    w_cs2 = 1'b0;

    // random traffic against the model
    downloading = 1'b1;
    tick();
    downloading = 1'b0;
    for (int s = 0; s < 3; s++) begin
      mv[s] = 1'b0; mt[s] = 0; md[s] = '0;
    end
    for (int it = 0; it < 80; it++) begin
      int  ad[3];
      bit  c[3];
      bit  hit;
      int  sel;
      int  k;
      sel = -1;
      for (int s = 0; s < 3; s++) c[s] = 1'($urandom_range(0, 1));
      ad[0] = $urandom_range(0, 15);
      ad[1] = $urandom_range(0, 3);
      ad[2] = $urandom_range(0, 3);
      cs0 = c[0]; cs1 = c[1]; cs2 = c[2];
      a0 = 15'(ad[0]); a1 = 13'(ad[1]); a2 = 13'(ad[2]);
      #1;
      for (int s = 0; s < 3; s++) begin
        hit = c[s] && mv[s] && mt[s] == mtag(s, ad[s]);
        chk($sformatf("rnd%0d_ok%0d", it, s), 64'(get_ok(s)), 64'(hit));
        if (hit)
          chk($sformatf("rnd%0d_dout%0d", it, s), 64'(get_dout(s)),
              64'(mdout(s, ad[s])));
        if (c[s] && !hit && sel < 0) sel = s;
      end
      if (sel < 0) begin
        sd.sdram_ack = 1'($urandom_range(0, 1));
        sd.data_rdy  = 1'($urandom_range(0, 1));
        sd.data_read = $urandom;
        tick();
        sd.sdram_ack = 1'b0;
        sd.data_rdy  = 1'b0;
        chk($sformatf("rnd%0d_noreq", it), 64'(sd.sdram_req), 64'(0));
        chk($sformatf("rnd%0d_refresh", it), 64'(refresh_en), 64'(1));
      end else begin
        logic [31:0] wd;
        tick();
        chk($sformatf("rnd%0d_req", it), 64'(sd.sdram_req), 64'(1));
        chk($sformatf("rnd%0d_addr", it), 64'(sd.sdram_addr),
            64'(maddr(sel, ad[sel])));
        k = $urandom_range(0, 3);
        repeat (k) begin
          sd.data_rdy  = 1'($urandom_range(0, 1));
          sd.data_read = $urandom;
          tick();
          sd.data_rdy  = 1'b0;
          chk($sformatf("rnd%0d_reqhold", it), 64'(sd.sdram_req), 64'(1));
          chk($sformatf("rnd%0d_early_ok", it), 64'(get_ok(sel)), 64'(0));
        end
        sd.sdram_ack = 1'b1;
        tick();
        sd.sdram_ack = 1'b0;
        chk($sformatf("rnd%0d_reqdrop", it), 64'(sd.sdram_req), 64'(0));
        k = $urandom_range(0, 3);
        repeat (k) begin
          sd.sdram_ack = 1'($urandom_range(0, 1));
          tick();
          sd.sdram_ack = 1'b0;
          chk($sformatf("rnd%0d_wait_req", it), 64'(sd.sdram_req), 64'(0));
        end
        wd = $urandom;
        sd.data_read = wd;
        sd.data_rdy  = 1'b1;
        tick();
        sd.data_rdy  = 1'b0;
        mv[sel] = 1'b1;
        mt[sel] = mtag(sel, ad[sel]);
        md[sel] = wd;
        chk($sformatf("rnd%0d_fill_ok", it), 64'(get_ok(sel)), 64'(1));
        chk($sformatf("rnd%0d_fill_dout", it), 64'(get_dout(sel)),
            64'(mdout(sel, ad[sel])));
      end
    end
    cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
